// File: rtl/rom_port_arb.sv
// Arbitrates a single ROM/frame-memory port between the video scanner (absolute
// priority) and a pixel update writer, with blanking-only write mode and status.
module rom_port_arb #(
  parameter logic [16:0] ADDR_MAX = 17'd76799,
  parameter int          DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vid_de,
  input  logic          vid_vs,
  input  logic [16:0]   vid_addr,
  input  logic          wr_mode,
  input  logic          wr_req,
  input  logic [16:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          wr_err,
  input  logic          stat_clr,
  output logic [15:0]   blk_cnt,
  output logic [16:0]   mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid
);

  typedef enum logic [1:0] {IDLE, VID, WR} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       window;
  logic       addr_ok;
  logic       vs_d;
  logic       blank;
  logic [1:0] de_pipe;

  assign window  = !wr_mode || blank;
  assign addr_ok = (wr_addr <= ADDR_MAX);

  // A cycle in WR is the ack cycle, so a still-high wr_req is not re-granted there.
  always_comb begin
    state_nxt = IDLE;
    if (vid_de)
      state_nxt = VID;
    else if (wr_req && window && (state != WR))
      state_nxt = WR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
      case (state_nxt)
        VID: mem_addr <= vid_addr;
        WR: begin
          wr_ack <= 1'b1;
          if (addr_ok) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
          end
        end
        default: ;
      endcase
      if (stat_clr)
        wr_err <= 1'b0;
      else if (state_nxt == WR && !addr_ok)
        wr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      blk_cnt <= '0;
    else if (stat_clr)
      blk_cnt <= '0;
    else if (wr_req && vid_de && blk_cnt != 16'hFFFF)
      blk_cnt <= blk_cnt + 16'd1;
  end

  // Blanking lasts from just after the field sync edge until active video resumes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_d  <= 1'b0;
      blank <= 1'b0;
    end else begin
      vs_d <= vid_vs;
      if (vid_de)
        blank <= 1'b0;
      else if (vid_vs && !vs_d)
        blank <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_pipe   <= '0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
    end else begin
      de_pipe   <= {de_pipe[0], vid_de};
      vid_valid <= de_pipe[1];
      if (de_pipe[1])
        vid_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_rom_port_arb.sv
// Randomized and directed bench for rom_port_arb against a behavioural model of
// the port arbitration rules and a pattern ROM (data = address + 0x100).
module tb_rom_port_arb;

  localparam logic [16:0] ADDR_MAX = 17'd76799;
  localparam int          DW       = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vid_de = 1'b0, vid_vs = 1'b0, wr_mode = 1'b0, wr_req = 1'b0, stat_clr = 1'b0;
  logic [16:0]   vid_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem_rdata;
  logic          wr_ack, wr_err, mem_we, vid_valid;
  logic [15:0]   blk_cnt;
  logic [16:0]   mem_addr;
  logic [DW-1:0] mem_wdata, vid_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs and model state
  logic          e_ack, e_we, e_err, e_valid;
  logic [16:0]   e_addr;
  logic [15:0]   e_wdata, e_data, e_blk;
  bit            m_blank, m_vs_prev;
  bit            qde[$];
  logic [15:0]   qdat[$];

  rom_port_arb #(.ADDR_MAX(ADDR_MAX), .DW(DW)) dut (
    .clk(clk), .rst(rst), .vid_de(vid_de), .vid_vs(vid_vs), .vid_addr(vid_addr),
    .wr_mode(wr_mode), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .stat_clr(stat_clr), .blk_cnt(blk_cnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .vid_data(vid_data), .vid_valid(vid_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [16:0] a);
    return a[15:0] + 16'h0100;
  endfunction

  always @(posedge clk) mem_rdata <= rom(mem_addr);

  task automatic model_reset();
    e_ack = 0; e_we = 0; e_err = 0; e_valid = 0;
    e_addr = '0; e_wdata = '0; e_data = '0; e_blk = '0;
    m_blank = 0; m_vs_prev = 0;
    qde = {1'b0, 1'b0};
    qdat = {16'h0, 16'h0};
  endtask

  // Advance the model by one cycle using the inputs now applied, then move the
  // bench to just after the next rising edge where those results are visible.
  task automatic tick();
    bit          window, grant_wr, ok;
    logic [15:0] d;
    window   = !wr_mode || m_blank;
    grant_wr = !vid_de && wr_req && window && !e_ack;
    ok       = (wr_addr <= ADDR_MAX);
    if (vid_de) e_addr = vid_addr;
    else if (grant_wr && ok) begin e_addr = wr_addr; e_wdata = wr_data; end
    e_ack = grant_wr;
    e_we  = grant_wr && ok;
    if (stat_clr) e_err = 0; else if (grant_wr && !ok) e_err = 1;
    if (stat_clr) e_blk = 0; else if (wr_req && vid_de && e_blk != 16'hFFFF) e_blk = e_blk + 16'd1;
    if (vid_de) m_blank = 0; else if (vid_vs && !m_vs_prev) m_blank = 1;
    m_vs_prev = vid_vs;
    qde.push_back(vid_de);
    qdat.push_back(rom(vid_addr));
    e_valid = qde.pop_front();
    d = qdat.pop_front();
    if (e_valid) e_data = d;
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    vid_de = 0; wr_req = 0; vid_vs = 0; stat_clr = 0;
    #1 rst = 1'b0;
    #2;
    n_checks++;
    if ({wr_ack, wr_err, blk_cnt, mem_addr, mem_we, mem_wdata, vid_data, vid_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b err=%b blk=%h addr=%h we=%b wd=%h vd=%h vv=%b required all zero",
               wr_ack, wr_err, blk_cnt, mem_addr, mem_we, mem_wdata, vid_data, vid_valid);
    end
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic test_video_latency();
    bit exp_v;
    for (int k = 0; k < 8; k++) begin
      vid_de = (k < 4); vid_addr = 17'(k);
      tick();
      exp_v = (k + 1 >= 3) && (k + 1 <= 6);
      n_checks++;
      if (vid_valid !== exp_v) begin
        n_fail++; $display("FAIL vid_valid cycle %0d got %b required %b", k + 1, vid_valid, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (vid_data !== 16'h0100 + 16'(k - 2)) begin
          n_fail++; $display("FAIL vid_data cycle %0d got %h required %h", k + 1, vid_data, 16'h0100 + 16'(k - 2));
        end
      end
      if (k < 4) begin
        n_checks++;
        if (mem_addr !== 17'(k) || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL vid_mem_addr cycle %0d got addr=%h we=%b required addr=%h we=0", k + 1, mem_addr, mem_we, k);
        end
      end
    end
    vid_de = 0;
  endtask

  task automatic test_write_blocked();
    int acks = 0;
    stat_clr = 1; tick(); stat_clr = 0;
    wr_mode = 0; wr_req = 1; wr_addr = 17'd5; wr_data = 16'hABCD;
    vid_de = 1; vid_addr = 17'd100;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (mem_we !== 1'b0 || wr_ack !== 1'b0) begin
        n_fail++; $display("FAIL blocked_we cycle %0d got we=%b ack=%b required 0/0", k, mem_we, wr_ack);
      end
    end
    n_checks++;
    if (blk_cnt !== 16'd3) begin
      n_fail++; $display("FAIL blk_cnt_3 got %0d required 3", blk_cnt);
    end
    vid_de = 0;
    tick();
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 17'd5 || mem_wdata !== 16'hABCD || wr_ack !== 1'b1) begin
      n_fail++; $display("FAIL write_after_de got we=%b addr=%h data=%h ack=%b required 1/00005/abcd/1",
                         mem_we, mem_addr, mem_wdata, wr_ack);
    end
    if (wr_ack === 1'b1) acks++;
    wr_req = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (wr_ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks != 1 || mem_addr !== 17'd5 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL single_ack got acks=%0d addr=%h we=%b required 1/00005/0", acks, mem_addr, mem_we);
    end
  endtask

  task automatic test_back_to_back();
    wr_mode = 0; vid_de = 0; wr_req = 1; wr_addr = 17'd20; wr_data = 16'h1234;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (wr_ack !== ((k % 2) == 0)) begin
        n_fail++; $display("FAIL b2b_ack step %0d got %b required %b", k, wr_ack, (k % 2) == 0);
      end
    end
    wr_req = 0; tick();
  endtask

  task automatic test_blank_mode();
    int  waited;
    bit  seen;
    wr_mode = 1; vid_vs = 0; vid_de = 0; wr_req = 1; wr_addr = 17'd7; wr_data = 16'h0707;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL pre_vs_ack step %0d got %b required 0", k, wr_ack); end
    end
    for (int pass = 0; pass < 2; pass++) begin
      vid_vs = 1; wr_req = 1; seen = 0; waited = 0;
      while (!seen && waited < 3) begin
        tick(); waited++;
        if (wr_ack === 1'b1 && mem_we === 1'b1) seen = 1;
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL vs_write pass %0d got no write within %0d cycles required write", pass, waited); end
      wr_req = 0; tick();
      vid_de = 1; tick(); vid_de = 0; wr_req = 1;
      for (int k = 0; k < 4; k++) begin
        tick();
        n_checks++;
        if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL held_after_de pass %0d step %0d got %b required 0", pass, k, wr_ack); end
      end
      vid_vs = 0; tick();
    end
    wr_req = 0; wr_mode = 0; tick();
  endtask

  task automatic test_bad_addr();
    wr_mode = 0; vid_de = 0; wr_req = 1; wr_addr = 17'd76800; wr_data = 16'hDEAD;
    tick();
    n_checks++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b0 || wr_err !== 1'b1) begin
      n_fail++; $display("FAIL bad_addr got ack=%b we=%b err=%b required 1/0/1", wr_ack, mem_we, wr_err);
    end
    wr_req = 0; vid_de = 1; tick(); vid_de = 0;
    wr_req = 1; wr_addr = ADDR_MAX; wr_data = 16'h5A5A;
    tick();
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== ADDR_MAX || wr_err !== 1'b1) begin
      n_fail++; $display("FAIL last_addr got we=%b addr=%h err=%b required 1/12bff/1", mem_we, mem_addr, wr_err);
    end
    wr_req = 0; stat_clr = 1; tick(); stat_clr = 0;
    n_checks++;
    if (wr_err !== 1'b0 || blk_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stat_clr got err=%b blk=%0d required 0/0", wr_err, blk_cnt);
    end
    wr_req = 1; wr_addr = 17'h1FFFF; stat_clr = 1;
    tick(); stat_clr = 0; wr_req = 0;
    n_checks++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
      n_fail++; $display("FAIL clr_wins_err got ack=%b err=%b required 1/0", wr_ack, wr_err);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      vid_de   = ($urandom_range(0, 2) == 0);
      vid_addr = 17'($urandom_range(0, 76799));
      if ($urandom_range(0, 19) == 0) vid_vs = ~vid_vs;
      if ($urandom_range(0, 49) == 0) wr_mode = ~wr_mode;
      wr_req   = $urandom_range(0, 1);
      wr_addr  = ($urandom_range(0, 7) == 0) ? ADDR_MAX + 17'($urandom_range(1, 3))
                                             : 17'($urandom_range(0, 76799));
      wr_data  = 16'($urandom);
      stat_clr = ($urandom_range(0, 39) == 0);
      tick();
      n_checks += 6;
      if (wr_ack !== e_ack)   begin n_fail++; $display("FAIL rnd_ack c%0d got %b required %b", c, wr_ack, e_ack); end
      if (mem_we !== e_we)    begin n_fail++; $display("FAIL rnd_we c%0d got %b required %b", c, mem_we, e_we); end
      if (mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr c%0d got %h required %h", c, mem_addr, e_addr); end
      if (wr_err !== e_err)   begin n_fail++; $display("FAIL rnd_err c%0d got %b required %b", c, wr_err, e_err); end
      if (blk_cnt !== e_blk)  begin n_fail++; $display("FAIL rnd_blk c%0d got %h required %h", c, blk_cnt, e_blk); end
      if (vid_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %b required %b", c, vid_valid, e_valid); end
      if (e_we) begin
        n_checks++;
        if (mem_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d got %h required %h", c, mem_wdata, e_wdata); end
      end
      if (e_valid) begin
        n_checks++;
        if (vid_data !== e_data) begin n_fail++; $display("FAIL rnd_vdata c%0d got %h required %h", c, vid_data, e_data); end
      end
    end
    vid_de = 0; vid_vs = 0; wr_mode = 0; wr_req = 0; stat_clr = 0;
    tick(); tick();
  endtask

  task automatic test_reset_during_write();
    wr_mode = 0; vid_de = 0; wr_req = 1; wr_addr = 17'd9; wr_data = 16'h0909;
    tick();
    n_checks++;
    if (mem_we !== 1'b1 || wr_ack !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_grant got we=%b ack=%b required 1/1", mem_we, wr_ack);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({wr_ack, wr_err, blk_cnt, mem_addr, mem_we, mem_wdata, vid_data, vid_valid} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got ack=%b we=%b addr=%h wd=%h blk=%h required all zero",
               wr_ack, mem_we, mem_addr, mem_wdata, blk_cnt);
    end
    release_reset();
    tick();
    n_checks++;
    if (wr_ack !== 1'b1 || mem_addr !== 17'd9) begin
      n_fail++; $display("FAIL re_request got ack=%b addr=%h required 1/00009", wr_ack, mem_addr);
    end
    wr_req = 0; tick();
  endtask

  task automatic test_saturation();
    stat_clr = 1; tick(); stat_clr = 0;
    wr_req = 1; vid_de = 1; vid_addr = 17'd1;
    for (int k = 0; k < 70000; k++) tick();
    n_checks++;
    if (blk_cnt !== 16'hFFFF || e_blk !== 16'hFFFF) begin
      n_fail++; $display("FAIL blk_saturate got %h required ffff", blk_cnt);
    end
    stat_clr = 1; tick(); stat_clr = 0;
    n_checks++;
    if (blk_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL clr_wins_inc got %h required 0000", blk_cnt);
    end
    wr_req = 0; vid_de = 0; tick();
  endtask

  initial begin
    test_reset();
    test_video_latency();
    test_write_blocked();
    test_back_to_back();
    test_blank_mode();
    test_bad_addr();
    test_random();
    test_reset_during_write();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
